// File: rtl/seq_decoder_pkg.sv
// Shared encodings for seq_decoder: mode values, FSM states and the
// select-width to output-width helper.
package seq_decoder_pkg;

    localparam logic [1:0] MODE_DIRECT = 2'b00;
    localparam logic [1:0] MODE_SCAN   = 2'b01;
    localparam logic [1:0] MODE_SWEEP  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_SWEEP = 2'd2
    } state_t;

    function automatic int out_w(input int sel_w);
        return 1 << sel_w;
    endfunction

endpackage

// File: rtl/seq_decoder_if.sv
// Host-side bundle for seq_decoder; the dwell field exists only when
// DEC_DWELL_EN is defined.
interface seq_decoder_if #(
    parameter int SEL_W = 3
`ifdef DEC_DWELL_EN
    , parameter int DWELL_W = 8
`endif
);
    import seq_decoder_pkg::*;

    localparam int OUT_W = out_w(SEL_W);

    logic             g_n;
    logic [1:0]       mode;
    logic [SEL_W-1:0] sel;
    logic             load;
    logic             start;
`ifdef DEC_DWELL_EN
    logic [DWELL_W-1:0] dwell;
`endif
    logic [OUT_W-1:0] dec_out_n;
    logic [SEL_W-1:0] index;
    logic             busy;
    logic             sweep_done;

    modport master (
        output g_n, mode, sel, load, start,
`ifdef DEC_DWELL_EN
        output dwell,
`endif
        input  dec_out_n, index, busy, sweep_done
    );

    modport slave (
        input  g_n, mode, sel, load, start,
`ifdef DEC_DWELL_EN
        input  dwell,
`endif
        output dec_out_n, index, busy, sweep_done
    );

endinterface

// File: rtl/seq_decoder_onecold_decode.sv
// Combinational SEL_W -> 2**SEL_W active-low decode; index i pulls bit
// (OUT_W-1-i) low, and en_n=1 forces every line high.
module onecold_decode #(
    parameter int SEL_W = 3,
    parameter int OUT_W = 8
) (
    input  logic [SEL_W-1:0] sel,
    input  logic             en_n,
    output logic [OUT_W-1:0] out_n
);

    always_comb begin
        out_n = '1;
        for (int i = 0; i < OUT_W; i++) begin
            if (!en_n && sel == SEL_W'(OUT_W - 1 - i)) begin
                out_n[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/seq_decoder.sv
// Registered one-cold decoder with direct, continuous-scan and single-sweep
// modes. Define DEC_DWELL_EN to add the programmable dwell; otherwise D=1.
module seq_decoder #(
    parameter int SEL_W = 3
`ifdef DEC_DWELL_EN
    , parameter int DWELL_W = 8
`endif
) (
    input  logic          clk,
    input  logic          reset,
    seq_decoder_if.slave  bus
);
    import seq_decoder_pkg::*;

    localparam int OUT_W = out_w(SEL_W);
`ifdef DEC_DWELL_EN
    localparam int CNT_W = DWELL_W;
`else
    localparam int CNT_W = 1;
`endif
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(OUT_W - 1);

    state_t           state_q, state_d;
    logic [SEL_W-1:0] index_q, index_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_last;
    logic [OUT_W-1:0] dec_out_n_q, dec_out_n_d;
    logic             busy_q, busy_d;
    logic             sweep_done_q, sweep_done_d;
    logic             step;

`ifdef DEC_DWELL_EN
    logic [DWELL_W-1:0] dwell_q, dwell_d;

    // A latched dwell of 0 behaves as 1, so the terminal count is 0 for both.
    assign cnt_last = (dwell_q == '0) ? '0 : dwell_q - DWELL_W'(1);
`else
    assign cnt_last = '0;
`endif

    assign step = (cnt_q == cnt_last);

    always_comb begin
        state_d      = state_q;
        index_d      = index_q;
        cnt_d        = cnt_q;
        sweep_done_d = 1'b0;
`ifdef DEC_DWELL_EN
        dwell_d      = dwell_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.mode == MODE_SCAN || (bus.mode == MODE_SWEEP && bus.start)) begin
                    state_d = (bus.mode == MODE_SCAN) ? ST_SCAN : ST_SWEEP;
                    index_d = '0;
                    cnt_d   = '0;
`ifdef DEC_DWELL_EN
                    dwell_d = bus.dwell;
`endif
                end else if (bus.mode != MODE_SWEEP && bus.load) begin
                    index_d = bus.sel;
                end
            end
            ST_SCAN: begin
                if (bus.mode != MODE_SCAN) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (step) begin
                    index_d = index_q + SEL_W'(1);
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            ST_SWEEP: begin
                // A mode change aborts the sweep silently, even on its last cycle.
                if (bus.mode != MODE_SWEEP) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (step && index_q == LAST_IDX) begin
                    state_d      = ST_IDLE;
                    cnt_d        = '0;
                    sweep_done_d = 1'b1;
                end else if (step) begin
                    index_d = index_q + SEL_W'(1);
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    onecold_decode #(
        .SEL_W (SEL_W),
        .OUT_W (OUT_W)
    ) u_decode (
        .sel   (index_d),
        .en_n  (bus.g_n),
        .out_n (dec_out_n_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            index_q      <= '0;
            cnt_q        <= '0;
            dec_out_n_q  <= '1;
            busy_q       <= 1'b0;
            sweep_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            index_q      <= index_d;
            cnt_q        <= cnt_d;
            dec_out_n_q  <= dec_out_n_d;
            busy_q       <= busy_d;
            sweep_done_q <= sweep_done_d;
        end
    end

`ifdef DEC_DWELL_EN
    always_ff @(posedge clk) begin
        dwell_q <= dwell_d;
    end
`endif

    assign bus.dec_out_n  = dec_out_n_q;
    assign bus.index      = index_q;
    assign bus.busy       = busy_q;
    assign bus.sweep_done = sweep_done_q;

endmodule
